// File: rtl/pipe_inv_div.sv
// Sequential restoring divider: Q = F / D and R = F mod D, unsigned, N bits.
// Latency: N+1 edges from the accepted start to the DONE cycle (1 edge if D=0).
// No backpressure. start is taken only in IDLE; done is a one-cycle pulse.
// Optional self-check output chk_ok is enabled by macro PIPE_INV_DIV_CHECK_EN.
module pipe_inv_div #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_zero
`ifdef PIPE_INV_DIV_CHECK_EN
  ,
  output logic         chk_ok
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  f_reg;       // captured dividend, read MSB first via cnt
  logic [N-1:0]  d_reg;       // captured divisor
  logic [N-1:0]  quo;         // quotient bits collected so far
  logic [N:0]    part;        // partial remainder, one spare bit so the shift never overflows
  logic [CW-1:0] cnt;         // index of the dividend bit consumed this cycle

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          q_bit;
  logic [N:0]    part_nxt;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;

  // One restoring step: shift in the next dividend bit, subtract D if it fits.
  always_comb begin
    shifted  = (part << 1) | {{N{1'b0}}, f_reg[cnt]};
    diff     = shifted - {1'b0, d_reg};
    q_bit    = (shifted >= {1'b0, d_reg});
    part_nxt = q_bit ? diff : shifted;
    q_fin    = {quo[N-2:0], q_bit};
    r_fin    = part_nxt[N-1:0];
  end

`ifdef PIPE_INV_DIV_CHECK_EN
  logic [2*N-1:0] recon;
  logic           chk_nxt;

  // Reconstruct Q*D+R in 2N bits and compare against the captured dividend.
  always_comb begin
    recon   = ({{N{1'b0}}, q_fin} * {{N{1'b0}}, d_reg}) + {{N{1'b0}}, r_fin};
    chk_nxt = (recon == {{N{1'b0}}, f_reg}) && (r_fin < d_reg);
  end
`endif

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (D != '0) ? DIV : DONE;
      end
      DIV: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_reg    <= '0;
      d_reg    <= '0;
      quo      <= '0;
      part     <= '0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
`ifdef PIPE_INV_DIV_CHECK_EN
      chk_ok   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (D != '0) begin
              f_reg <= F;
              d_reg <= D;
              quo   <= '0;
              part  <= '0;
              cnt   <= CW'(N - 1);
            end else begin
              // Divide by zero: saturated quotient, dividend passes through.
              Q        <= '1;
              R        <= F;
              div_zero <= 1'b1;
`ifdef PIPE_INV_DIV_CHECK_EN
              chk_ok   <= 1'b0;
`endif
            end
          end
        end
        DIV: begin
          part <= part_nxt;
          quo  <= q_fin;
          if (cnt == '0) begin
            Q        <= q_fin;
            R        <= r_fin;
            div_zero <= 1'b0;
`ifdef PIPE_INV_DIV_CHECK_EN
            chk_ok   <= chk_nxt;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_inv_div.sv
// Bench for pipe_inv_div: directed scenarios plus randomized divisions.
// Reference results come from plain integer / and % in the bench.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pipe_inv_div;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] F;
  logic [N-1:0] D;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_zero;
`ifdef PIPE_INV_DIV_CHECK_EN
  logic         chk_ok;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_inv_div #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .F        (F),
    .D        (D),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .R        (R),
    .div_zero (div_zero)
`ifdef PIPE_INV_DIV_CHECK_EN
    ,
    .chk_ok   (chk_ok)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division. k = edges from the start edge (inclusive) to the first
  // sample with done high; bc = samples with busy high over the same span.
  task automatic run_div(input logic [N-1:0] f, input logic [N-1:0] d,
                         input bit toggle, input bit keep_start,
                         output int k, output int bc);
    F = f;
    D = d;
    start = 1'b1;
    tick();
    k  = 1;
    bc = busy ? 1 : 0;
    if (!keep_start) start = 1'b0;
    while (!done && k < 40) begin
      if (toggle) begin
        F     = N'($urandom);
        D     = N'($urandom);
        start = 1'($urandom);
      end
      tick();
      k++;
      if (busy) bc++;
    end
    if (!keep_start) begin
      start = 1'b0;
      tick();
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] f, input logic [N-1:0] d,
                              input int k, input int bc, input logic [N-1:0] q_obs,
                              input logic [N-1:0] r_obs, input logic dz_obs, input logic chk_obs);
    int unsigned fi, di, eq, er, lat;
    fi  = f;
    di  = d;
    eq  = (di == 0) ? (2**N - 1) : fi / di;
    er  = (di == 0) ? fi : fi % di;
    lat = (di == 0) ? 1 : N + 1;
    check({tag, " latency"}, k, lat);
    check({tag, " busy_cycles"}, bc, lat);
    check({tag, " Q"}, q_obs, eq);
    check({tag, " R"}, r_obs, er);
    check({tag, " div_zero"}, dz_obs, (di == 0) ? 1 : 0);
`ifdef PIPE_INV_DIV_CHECK_EN
    check({tag, " chk_ok"}, chk_obs, (di == 0) ? 0 : 1);
`else
    if (chk_obs !== 1'b0) check({tag, " chk_tie"}, chk_obs, 0);
`endif
  endtask

  function automatic logic chk_val();
`ifdef PIPE_INV_DIV_CHECK_EN
    return chk_ok;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int k, bc, k2, seen;
    logic [N-1:0] rf, rd;
    bit tg;

    rst = 1'b1; start = 1'b0; F = '0; D = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset Q", Q, 0);
    check("reset R", R, 0);
    check("reset div_zero", div_zero, 0);
`ifdef PIPE_INV_DIV_CHECK_EN
    check("reset chk_ok", chk_ok, 0);
`endif

    // 99 / 3, then results must hold while idle.
    run_div(10'd99, 10'd3, 1'b0, 1'b0, k, bc);
    check_result("99/3", 10'd99, 10'd3, k, bc, Q, R, div_zero, chk_val());
    check("99/3 idle busy", busy, 0);
    check("99/3 idle done", done, 0);
    tick(); tick(); tick();
    check("99/3 hold Q", Q, 33);
    check("99/3 hold R", R, 0);

    run_div(10'd1023, 10'd7, 1'b0, 1'b0, k, bc);
    check_result("1023/7", 10'd1023, 10'd7, k, bc, Q, R, div_zero, chk_val());

    // Back-to-back: start held high through the first result.
    run_div(10'd150, 10'd10, 1'b0, 1'b1, k, bc);
    check_result("150/10", 10'd150, 10'd10, k, bc, Q, R, div_zero, chk_val());
    F = 10'd116;
    D = 10'd4;
    k2 = 0;
    do begin
      tick();
      k2++;
    end while (!done && k2 < 40);
    start = 1'b0;
    check("b2b spacing", k2, N + 2);
    check("b2b Q", Q, 29);
    check("b2b R", R, 0);
    tick();
    tick();
    check("b2b idle busy", busy, 0);

    run_div(10'd62, 10'd0, 1'b0, 1'b0, k, bc);
    check_result("62/0", 10'd62, 10'd0, k, bc, Q, R, div_zero, chk_val());

    // Reset in the middle of a division.
    F = 10'd66; D = 10'd3; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (done) seen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort Q", Q, 0);
    check("abort R", R, 0);
    check("abort div_zero", div_zero, 0);
    repeat (15) begin
      tick();
      if (done) seen++;
    end
    check("abort no_done", seen, 0);
    run_div(10'd49, 10'd1, 1'b0, 1'b0, k, bc);
    check_result("49/1", 10'd49, 10'd1, k, bc, Q, R, div_zero, chk_val());

    // Inputs scrambled during DIV must not change the result.
    run_div(10'd0, 10'd5, 1'b1, 1'b0, k, bc);
    check_result("0/5 toggled", 10'd0, 10'd5, k, bc, Q, R, div_zero, chk_val());

    for (int i = 0; i < 24; i++) begin
      rf = N'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      tg = 1'($urandom);
      run_div(rf, rd, tg, 1'b0, k, bc);
      check_result("random", rf, rd, k, bc, Q, R, div_zero, chk_val());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_inv_div.md
PIPE_INV_DIV -- requirements
Module: pipe_inv_div

Interface
REQ-001 SHALL have parameter N, default 10, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port F, input, N bits, unsigned dividend (the pipeline product).
REQ-006 SHALL have port D, input, N bits, unsigned divisor (the pipeline D operand).
REQ-007 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse marking Q, R and div_zero valid.
REQ-009 SHALL have port Q, output, N bits, quotient, i.e. the recovered stage-2 sum F/D.
REQ-010 SHALL have port R, output, N bits, remainder F mod D.
REQ-011 SHALL have port div_zero, output, 1 bit, high when the last accepted D was 0.

Function
REQ-012 SHALL implement the FSM states IDLE, DIV and DONE.
REQ-013 Transition IDLE->DIV SHALL occur on an edge with start=1 and D!=0.
REQ-014 On that edge the block SHALL capture F and D internally, clear the partial remainder and load the iteration counter with N-1.
REQ-015 Transition IDLE->DONE SHALL occur on an edge with start=1 and D=0.
REQ-016 For that divide-by-zero case: Q SHALL be all ones, R SHALL equal F, and div_zero SHALL be 1.
REQ-017 DIV SHALL perform one restoring-division step per cycle, MSB first: shift partial remainder left and bring in the next dividend bit.
REQ-018 In each step, if partial >= D, the block SHALL subtract D and set the quotient bit to 1; otherwise it SHALL set the quotient bit to 0.
REQ-019 The partial remainder SHALL be N+1 bits wide, so that no intermediate overflow occurs for any F and D.
REQ-020 DIV->DONE SHALL occur on the edge that processes counter value 0; the state SHALL be DIV for exactly N cycles.
REQ-021 The edge entering DONE SHALL update Q, R and div_zero; div_zero SHALL be 0 when D!=0.
REQ-022 done SHALL be 1 only while in DONE; for D!=0 it SHALL assert N+1 edges after the start-sampling edge (11 for N=10).
REQ-023 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-024 Q, R and div_zero SHALL hold their values until the next entry to DONE.
REQ-025 start SHALL be ignored in DIV and DONE; changes to F and D after capture SHALL not affect the result.
REQ-026 Back-to-back use: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one result per N+2 cycles.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE and clear the counter and all internal registers.
REQ-028 After reset: busy=0, done=0, Q=0, R=0, div_zero=0.
REQ-029 rst SHALL take priority over start and over any in-progress division.
REQ-030 A division aborted by reset SHALL produce no done pulse.

Configuration
REQ-031 With macro PIPE_INV_DIV_CHECK_EN defined, the block SHALL add output port chk_ok, 1 bit.
REQ-032 chk_ok SHALL be registered on the edge entering DONE, and SHALL be 1 iff Q*D+R, computed in 2N bits, equals F zero-extended and R<D.
REQ-033 When the division was by zero, chk_ok SHALL be 0.
REQ-034 chk_ok SHALL reset to 0 and otherwise hold like Q.
REQ-035 Without PIPE_INV_DIV_CHECK_EN, chk_ok and its multiplier logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=10)
REQ-036 Scenario: F=99, D=3, start pulse -> done exactly 11 edges later; Q=33, R=0, div_zero=0, busy high for 11 cycles.
REQ-037 Scenario: F=1023, D=7 -> Q=146, R=1; with PIPE_INV_DIV_CHECK_EN, chk_ok=1.
REQ-038 Scenario: F=150, D=10 -> Q=15, R=0; then immediately F=116, D=4 with start held high -> second done 12 edges after the first, Q=29, R=0, start ignored while busy.
REQ-039 Scenario: F=62, D=0 -> done 1 edge after start; Q=1023, R=62, div_zero=1, chk_ok=0.
REQ-040 Scenario: F=66, D=3, rst pulsed 5 cycles after start -> busy=0, Q=0, R=0, no done pulse; a new start with F=49, D=1 -> Q=49, R=0.
REQ-041 Scenario: F=0, D=5 -> Q=0, R=0; F, D toggled randomly during DIV -> result unchanged.
